// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths and types for the pipe_reg_chain elastic pipeline.
package pipe_pkg;
  localparam int STALL_CNT_W = 32;
  typedef logic valid_bit_t;
  function automatic int occ_w(int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one load-enabled valid+data register with flush and async active-low clear.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output valid_bit_t       valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= flush ? 1'b0 : (load ? src_valid : valid);
      if (load && src_valid && !flush) data <= src_data;
    end
  end
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage elastic valid/ready register chain with flush.
// Defining PIPE_REG_PERF_EN adds the stall_cycles counter port.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [occ_w(DEPTH)-1:0]   occupancy
`ifdef PIPE_REG_PERF_EN
  ,output logic [STALL_CNT_W-1:0]   stall_cycles
`endif
);
  localparam int OCC_W = occ_w(DEPTH);
  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be >= 1");
  end
  valid_bit_t [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] sd [DEPTH];
  logic [DEPTH-1:0] sv;
  logic [DEPTH:0] rdy;
  // A stage can take new data when it is empty or its occupant is moving on.
  always_comb begin
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) rdy[k] = !v[k] || rdy[k+1];
  end
  always_comb begin
    sv[0] = in_valid;
    sd[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      sv[k] = v[k-1];
      sd[k] = d[k-1];
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .load      (rdy[i]),
      .src_valid (sv[i]),
      .src_data  (sd[i]),
      .valid     (v[i]),
      .data      (d[i])
    );
  end
  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OCC_W'(v[k]);
  end
`ifdef PIPE_REG_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cycles <= '0;
    else if (out_valid && !out_ready) stall_cycles <= stall_cycles + STALL_CNT_W'(1);
  end
`endif
endmodule
